fifo_wptr_full: RTL and testbench

//  Write-domain pointer and full-flag generator for the async FIFO, directly upstream of fifomem.

---
 rtl/fifo_pkg.sv | 29 ++
 rtl/fifo_wptr_full_if.sv | 42 ++++
 rtl/fifo_wptr_full.sv | 96 +++++++++
 tb/tb_fifo_wptr_full.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared helpers for the async FIFO pointer blocks (write and read side).
// The Gray conversions are written on a fixed 32-bit container. Callers
// zero-extend their pointer into it and keep the low bits of the result.
// Zero upper bits convert to zero upper bits, so the low bits are correct
// for any pointer width up to PTR_MAX_W.
// -----------------------------------------------------------------------------
package fifo_pkg;

  localparam int PTR_MAX_W = 32;

  typedef logic [PTR_MAX_W-1:0] ptr_max_t;

  function automatic ptr_max_t bin2gray(input ptr_max_t b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic ptr_max_t gray2bin(input ptr_max_t g);
    ptr_max_t b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_wptr_full_if.sv
// -----------------------------------------------------------------------------
// fifo_wptr_full_if
// Write-domain bundle between the producer, the read-pointer synchroniser,
// fifomem and the write-pointer/full block.
//   master : producer / environment side (drives winc, wq2_rptr, wclr_ovf)
//   slave  : fifo_wptr_full (drives address, enable, pointer and flags)
// Signals:
//   winc          write request
//   wq2_rptr      read Gray pointer already synchronised into wclk
//   wclr_ovf      clear sticky overflow
//   waddr         binary write address to fifomem
//   wclken        write enable to fifomem
//   wptr          registered Gray write pointer
//   wfull         full flag
//   walmost_full  almost-full flag
//   wlevel        occupied entries, 0..DEPTH
//   woverflow     sticky write-while-full flag
// -----------------------------------------------------------------------------
interface fifo_wptr_full_if #(
  parameter int ADDRSIZE = 4
);
  logic                winc;
  logic [ADDRSIZE:0]   wq2_rptr;
  logic                wclr_ovf;
  logic [ADDRSIZE-1:0] waddr;
  logic                wclken;
  logic [ADDRSIZE:0]   wptr;
  logic                wfull;
  logic                walmost_full;
  logic [ADDRSIZE:0]   wlevel;
  logic                woverflow;

  modport master (
    output winc, wq2_rptr, wclr_ovf,
    input  waddr, wclken, wptr, wfull, walmost_full, wlevel, woverflow
  );

  modport slave (
    input  winc, wq2_rptr, wclr_ovf,
    output waddr, wclken, wptr, wfull, walmost_full, wlevel, woverflow
  );
endinterface

// File: rtl/fifo_wptr_full.sv
// -----------------------------------------------------------------------------
// fifo_wptr_full
// Write-domain pointer and full-flag generator of the async FIFO.
// Holds the binary write address and the Gray write pointer, gates writes
// into fifomem, and compares against the read pointer already synchronised
// into wclk. From that it derives full, almost-full, fill level and a sticky
// overflow flag. Full and level are pessimistic: a read only frees space
// once its pointer has crossed the synchroniser.
// Ports:
//   wclk  write clock (sole clock)
//   wrst  synchronous active-high reset
//   wif   fifo_wptr_full_if.slave bundle (see interface header)
// Parameters:
//   ADDRSIZE      memory address bits (>= 2). DEPTH = 1 << ADDRSIZE.
//   AFULL_MARGIN  walmost_full when level >= DEPTH - AFULL_MARGIN (1..DEPTH-1)
// -----------------------------------------------------------------------------
module fifo_wptr_full
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE     = 4,
  parameter int AFULL_MARGIN = 2
) (
  input  logic           wclk,
  input  logic           wrst,
  fifo_wptr_full_if.slave wif
);

  localparam int DEPTH = 1 << ADDRSIZE;
  localparam int PW    = ADDRSIZE + 1;

  logic [PW-1:0] wbin_q,   wbin_d;
  logic [PW-1:0] wptr_q,   wptr_d;
  logic [PW-1:0] wlevel_q, wlevel_d;
  logic          wfull_q,  wfull_d;
  logic          wafull_q, wafull_d;
  logic          wovf_q,   wovf_d;

  logic          wr_ok;
  logic [PW-1:0] rbin;
  logic [PW-1:0] full_cmp;
  ptr_max_t      gray_w;
  ptr_max_t      rbin_w;
  logic          unused_hi_bits;

  always_comb begin
    wr_ok  = wif.winc & ~wfull_q;
    wbin_d = wbin_q + {{(PW-1){1'b0}}, wr_ok};

    gray_w = bin2gray(ptr_max_t'(wbin_d));
    wptr_d = gray_w[PW-1:0];

    rbin_w = gray2bin(ptr_max_t'(wif.wq2_rptr));
    rbin   = rbin_w[PW-1:0];

    // Full when the write pointer is exactly one lap ahead of the read
    // pointer. In Gray code that is the two MSBs inverted, the rest equal.
    full_cmp = {~wif.wq2_rptr[PW-1:PW-2], wif.wq2_rptr[PW-3:0]};
    wfull_d  = (wptr_d == full_cmp);

    // Modular difference; equals DEPTH exactly in the full case.
    wlevel_d = wbin_d - rbin;
    wafull_d = (ptr_max_t'(wlevel_d) >= ptr_max_t'(DEPTH - AFULL_MARGIN));

    // Setting wins over a simultaneous clear.
    wovf_d = (wif.winc & wfull_q) | (wovf_q & ~wif.wclr_ovf);
  end

  assign unused_hi_bits = ^{gray_w[PTR_MAX_W-1:PW], rbin_w[PTR_MAX_W-1:PW]};

  always_ff @(posedge wclk) begin
    if (wrst) begin
      wbin_q   <= '0;
      wptr_q   <= '0;
      wlevel_q <= '0;
      wfull_q  <= 1'b0;
      wafull_q <= 1'b0;
      wovf_q   <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wptr_q   <= wptr_d;
      wlevel_q <= wlevel_d;
      wfull_q  <= wfull_d;
      wafull_q <= wafull_d;
      wovf_q   <= wovf_d;
    end
  end

  assign wif.waddr        = wbin_q[ADDRSIZE-1:0];
  assign wif.wclken       = wr_ok;
  assign wif.wptr         = wptr_q;
  assign wif.wfull        = wfull_q;
  assign wif.walmost_full = wafull_q;
  assign wif.wlevel       = wlevel_q;
  assign wif.woverflow    = wovf_q;

endmodule

// File: tb/tb_fifo_wptr_full.sv
module tb_fifo_wptr_full;

  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AFM   = 2;

  logic wclk = 1'b0;
  logic wrst;

  always #5 wclk = ~wclk;

  fifo_wptr_full_if #(.ADDRSIZE(AW)) wif ();

  fifo_wptr_full #(.ADDRSIZE(AW), .AFULL_MARGIN(AFM)) dut (
    .wclk (wclk),
    .wrst (wrst),
    .wif  (wif)
  );

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    bit rst;
    bit inc;
    bit clr;
    int rd;      // read count (binary), driven as Gray
    int e_clken; // -1 = do not check
    bit e_full;
    bit e_afull;
    bit e_ovf;
    int e_level;
    int e_wptr;
    int e_waddr;
  } vec_t;

  vec_t tv[$];

  function automatic int gray(int b);
    return b ^ (b >> 1);
  endfunction

  function automatic vec_t mk(bit rst, bit inc, bit clr, int rd, int ck,
                              bit f, bit af, bit ov, int lv, int wp, int wa);
    vec_t v;
    v.rst = rst; v.inc = inc; v.clr = clr; v.rd = rd; v.e_clken = ck;
    v.e_full = f; v.e_afull = af; v.e_ovf = ov;
    v.e_level = lv; v.e_wptr = wp; v.e_waddr = wa;
    return v;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d required %0d", name, act, exp);
  endtask

  // Apply inputs away from the active edge, let combinational output settle.
  task automatic drive(bit rst, bit inc, bit clr, int rd);
    @(negedge wclk);
    wrst         = rst;
    wif.winc     = inc;
    wif.wclr_ovf = clr;
    wif.wq2_rptr = 5'(gray(rd % 32));
    #1;
  endtask

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  task automatic chk_regs(string tag, bit f, bit af, bit ov, int lv, int wp, int wa);
    chk({tag, ".wfull"},        int'(wif.wfull),        int'(f));
    chk({tag, ".walmost_full"}, int'(wif.walmost_full), int'(af));
    chk({tag, ".woverflow"},    int'(wif.woverflow),    int'(ov));
    chk({tag, ".wlevel"},       int'(wif.wlevel),       lv);
    chk({tag, ".wptr"},         int'(wif.wptr),         wp);
    chk({tag, ".waddr"},        int'(wif.waddr),        wa);
  endtask

  // Reference model state: counts of accepted writes and reads, unbounded.
  int m_wr, m_rd, lvl;
  bit m_full, m_afull, m_ovf, acc;
  int prev_wptr;

  initial begin
    wrst = 1'b1; wif.winc = 1'b0; wif.wclr_ovf = 1'b0; wif.wq2_rptr = '0;

    // ---------------- directed table ----------------
    tv.push_back(mk(1,1,0,0,-1, 0,0,0, 0, 0,0));
    tv.push_back(mk(1,0,0,0, 0, 0,0,0, 0, 0,0));
    for (int i = 1; i <= DEPTH; i++)
      tv.push_back(mk(0,1,0,0,1, i == DEPTH, i >= DEPTH-AFM, 0, i, gray(i % 32), i % DEPTH));
    tv.push_back(mk(0,1,0,0,0, 1,1,1,16,24,0));   // write while full dropped
    tv.push_back(mk(0,0,0,0,0, 1,1,1,16,24,0));   // sticky
    tv.push_back(mk(0,0,1,0,0, 1,1,0,16,24,0));   // clear
    tv.push_back(mk(0,1,1,0,0, 1,1,1,16,24,0));   // set beats clear
    tv.push_back(mk(0,0,1,0,0, 1,1,0,16,24,0));
    tv.push_back(mk(0,0,0,1,0, 0,1,0,15,24,0));   // one read frees a slot
    tv.push_back(mk(0,1,0,1,1, 1,1,0,16,25,1));   // refill
    tv.push_back(mk(0,1,0,1,0, 1,1,1,16,25,1));   // overflow again
    tv.push_back(mk(1,1,0,0,0, 0,0,0, 0, 0,0));   // mid-op reset dominates
    tv.push_back(mk(0,1,0,0,1, 0,0,0, 1, 1,1));

    for (int i = 0; i < tv.size(); i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      drive(tv[i].rst, tv[i].inc, tv[i].clr, tv[i].rd);
      if (tv[i].e_clken >= 0) chk({tag, ".wclken"}, int'(wif.wclken), tv[i].e_clken);
      tick();
      chk_regs(tag, tv[i].e_full, tv[i].e_afull, tv[i].e_ovf,
               tv[i].e_level, tv[i].e_wptr, tv[i].e_waddr);
    end

    // ---------------- wrap: 40 writes, reader one cycle behind ----------------
    drive(1, 0, 0, 0);
    tick();
    prev_wptr = 0;
    for (int k = 0; k < 40; k++) begin
      drive(0, 1, 0, k);
      chk("wrap.wclken", int'(wif.wclken), 1);
      tick();
      chk("wrap.wfull",  int'(wif.wfull),  0);
      chk("wrap.wlevel", int'(wif.wlevel), 1);
      chk("wrap.waddr",  int'(wif.waddr),  (k + 1) % DEPTH);
      chk("wrap.wptr",   int'(wif.wptr),   gray((k + 1) % 32));
      chk("wrap.gray1bit", $countones(int'(wif.wptr) ^ prev_wptr), 1);
      prev_wptr = int'(wif.wptr);
    end
    chk("wrap.final_wptr", int'(wif.wptr), 12);

    // ---------------- randomized vs. reference model ----------------
    drive(1, 0, 0, 0);
    tick();
    m_wr = 0; m_rd = 0; m_full = 0; m_afull = 0; m_ovf = 0;
    for (int c = 0; c < 800; c++) begin
      bit rst, inc, clr;
      rst = ($urandom % 150) == 0;
      inc = ($urandom % 10) < 7;
      clr = ($urandom % 12) == 0;
      if (rst) m_rd = 0;
      else if (m_rd < m_wr && ($urandom % 10) < 4) m_rd++;
      drive(rst, inc, clr, m_rd);
      chk("rnd.wclken", int'(wif.wclken), int'(inc && !m_full));
      tick();
      if (rst) begin
        m_wr = 0; m_rd = 0; m_full = 0; m_afull = 0; m_ovf = 0;
      end else begin
        acc   = inc && !m_full;
        m_ovf = (inc && m_full) || (m_ovf && !clr);
        m_wr  = m_wr + int'(acc);
        lvl   = m_wr - m_rd;
        m_full  = (lvl == DEPTH);
        m_afull = (lvl >= DEPTH - AFM);
      end
      chk_regs("rnd", m_full, m_afull, m_ovf, m_wr - m_rd, gray(m_wr % 32), m_wr % DEPTH);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
